// File: rtl/axis_axil_master_pkg.sv
// rtl/axis_axil_master_pkg.sv - opcodes, status layout and FSM states for axis_axil_master
package axis_axil_master_pkg;

    localparam logic [7:0] OP_WRITE      = 8'h01;
    localparam logic [7:0] OP_READ       = 8'h02;
    localparam logic [7:0] OP_WRITE_STRB = 8'h03;

    localparam int ST_FRAME_ERR = 7;
    localparam int ST_RESP_LSB  = 0;

    localparam logic [7:0] ERR_STATUS = 8'(1 << ST_FRAME_ERR);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        DATA,
        AXI_W,
        AXI_B,
        AXI_AR,
        AXI_R,
        RESP,
        DRAIN,
        ERR
    } state_t;

    // Status byte for a completed AXI transaction: frame error clear, resp in the low bits.
    function automatic logic [7:0] resp_status(input logic [1:0] resp);
        return 8'(resp) << ST_RESP_LSB;
    endfunction

    // WRITE_STRB is only legal when the strobe feature is built in.
    function automatic logic op_is_legal(input logic [7:0] op, input logic strb_en);
        return (op == OP_WRITE) || (op == OP_READ) || (strb_en && (op == OP_WRITE_STRB));
    endfunction

endpackage

// File: rtl/axis_resp_serializer.sv
// rtl/axis_resp_serializer.sv - shifts a {status, data} word out as a byte stream
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   load                     capture load_status/load_data and start sending load_count bytes
//   load_status, load_data   first byte, then NB data bytes (MSB first)
//   load_count               number of bytes to send (1 .. NB+1)
//   tdata/tvalid/tready/tlast  byte stream out, tlast on the final byte
module axis_resp_serializer
    #(
        parameter int NB = 4
    ) (
        input  logic            clk_i,
        input  logic            rst_i,
        input  logic            load,
        input  logic [7:0]      load_status,
        input  logic [8*NB-1:0] load_data,
        input  logic [7:0]      load_count,
        output logic [7:0]      tdata,
        output logic            tvalid,
        input  logic            tready,
        output logic            tlast
    );

    localparam int W = 8 * (NB + 1);

    logic [W-1:0] sr_q;
    logic [7:0]   left_q;
    logic         valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q    <= '0;
            left_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            sr_q    <= {load_status, load_data};
            left_q  <= load_count;
            valid_q <= 1'b1;
        end else if (valid_q && tready) begin
            if (left_q == 8'd1) begin
                valid_q <= 1'b0;
            end
            sr_q   <= {sr_q[W-9:0], 8'h00};
            left_q <= left_q - 8'd1;
        end
    end

    assign tdata  = sr_q[W-1 -: 8];
    assign tvalid = valid_q;
    assign tlast  = valid_q && (left_q == 8'd1);

endmodule

// File: rtl/axis_axil_master.sv
// rtl/axis_axil_master.sv - AXI-Lite master driven by a byte-wide command stream
//
// Optional feature macro: AXIL_MASTER_WSTRB_EN (adds opcode 0x03 WRITE_STRB with a trailing strobe byte).
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   s_axis_t*                    command bytes in: opcode, address MSB first, write data MSB first
//   m_axis_t*                    response bytes out: status, then read data MSB first
//   m_axil_aw*/w*/b*/ar*/r*      AXI-Lite master channels, prot fixed at 3'b000
module axis_axil_master
    import axis_axil_master_pkg::*;
    #(
        parameter int AXIL_ADDR_WIDTH = 32,
        parameter int AXIL_DATA_WIDTH = 32,
        parameter int AXIS_DATA_WIDTH = 8
    ) (
        input  logic                         clk_i,
        input  logic                         rst_i,
        input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
        input  logic                         s_axis_tvalid,
        output logic                         s_axis_tready,
        input  logic                         s_axis_tlast,
        output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
        output logic                         m_axis_tvalid,
        input  logic                         m_axis_tready,
        output logic                         m_axis_tlast,
        output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
        output logic [2:0]                   m_axil_awprot,
        output logic                         m_axil_awvalid,
        input  logic                         m_axil_awready,
        output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
        output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
        output logic                         m_axil_wvalid,
        input  logic                         m_axil_wready,
        input  logic [1:0]                   m_axil_bresp,
        input  logic                         m_axil_bvalid,
        output logic                         m_axil_bready,
        output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
        output logic [2:0]                   m_axil_arprot,
        output logic                         m_axil_arvalid,
        input  logic                         m_axil_arready,
        input  logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
        input  logic [1:0]                   m_axil_rresp,
        input  logic                         m_axil_rvalid,
        output logic                         m_axil_rready
    );

    localparam int NA = AXIL_ADDR_WIDTH / 8;
    localparam int NB = AXIL_DATA_WIDTH / 8;
    localparam logic [7:0] NA_LAST    = 8'(NA - 1);
    localparam logic [7:0] NB_LAST    = 8'(NB - 1);
    localparam logic [7:0] NB_CNT     = 8'(NB);
    localparam logic [7:0] READ_BYTES = 8'(NB + 1);
`ifdef AXIL_MASTER_WSTRB_EN
    localparam logic STRB_EN = 1'b1;
`else
    localparam logic STRB_EN = 1'b0;
`endif

    if (AXIS_DATA_WIDTH != 8 || (AXIL_ADDR_WIDTH % 8) != 0 || (AXIL_DATA_WIDTH % 8) != 0) begin : g_bad_params
        $error("axis_axil_master: stream width must be 8 and AXI-Lite widths multiples of 8");
    end

    state_t state, state_nxt;

    logic [7:0]                 op_q;
    logic [7:0]                 cnt_q;
    logic [AXIL_ADDR_WIDTH-1:0] addr_q;
    logic [AXIL_DATA_WIDTH-1:0] data_q;
    logic                       awvalid_q;
    logic                       wvalid_q;
    logic                       ready_en_q;

    logic       s_hs;
    logic [7:0] s_byte;
    logic [7:0] data_last;
    logic       field_end;
    logic       frame_last;
    logic       m_hs_last;

    logic                       ser_load;
    logic [7:0]                 ser_status;
    logic [AXIL_DATA_WIDTH-1:0] ser_data;
    logic [7:0]                 ser_count;

    // ready_en_q keeps tready low until the first edge after reset is released.
    assign s_axis_tready = ready_en_q && (state inside {IDLE, ADDR, DATA, DRAIN});
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign s_byte        = s_axis_tdata[7:0];
    assign m_hs_last     = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // WRITE_STRB carries one extra byte after the data field.
    assign data_last  = (STRB_EN && (op_q == OP_WRITE_STRB)) ? NB_CNT : NB_LAST;
    assign field_end  = (state == ADDR) && (cnt_q == NA_LAST);
    assign frame_last = (field_end && (op_q == OP_READ)) || ((state == DATA) && (cnt_q == data_last));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        m_axil_bready  = 1'b0;
        m_axil_rready  = 1'b0;
        m_axil_arvalid = 1'b0;
        ser_load       = 1'b0;
        ser_status     = '0;
        ser_data       = '0;
        ser_count      = 8'd1;
        case (state)
            IDLE: begin
                if (s_hs) begin
                    if (s_axis_tlast) begin
                        state_nxt = ERR;
                    end else if (op_is_legal(s_byte, STRB_EN)) begin
                        state_nxt = ADDR;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
            ADDR, DATA: begin
                if (s_hs) begin
                    if (frame_last) begin
                        if (!s_axis_tlast) begin
                            state_nxt = DRAIN;
                        end else begin
                            state_nxt = (op_q == OP_READ) ? AXI_AR : AXI_W;
                        end
                    end else if (s_axis_tlast) begin
                        state_nxt = ERR;
                    end else if (field_end) begin
                        state_nxt = DATA;
                    end
                end
            end
            DRAIN: begin
                if (s_hs && s_axis_tlast) begin
                    state_nxt = ERR;
                end
            end
            AXI_W: begin
                // Leave once neither channel still has an unaccepted beat.
                if (!(awvalid_q && !m_axil_awready) && !(wvalid_q && !m_axil_wready)) begin
                    state_nxt = AXI_B;
                end
            end
            AXI_B: begin
                m_axil_bready = 1'b1;
                if (m_axil_bvalid) begin
                    state_nxt  = RESP;
                    ser_load   = 1'b1;
                    ser_status = resp_status(m_axil_bresp);
                end
            end
            AXI_AR: begin
                m_axil_arvalid = 1'b1;
                if (m_axil_arready) begin
                    state_nxt = AXI_R;
                end
            end
            AXI_R: begin
                m_axil_rready = 1'b1;
                if (m_axil_rvalid) begin
                    state_nxt  = RESP;
                    ser_load   = 1'b1;
                    ser_status = resp_status(m_axil_rresp);
                    ser_data   = m_axil_rdata;
                    ser_count  = READ_BYTES;
                end
            end
            RESP, ERR: begin
                if (m_hs_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == ERR && state != ERR) begin
            ser_load   = 1'b1;
            ser_status = ERR_STATUS;
            ser_count  = 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q       <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (state == IDLE && s_hs) begin
                op_q  <= s_byte;
                cnt_q <= '0;
            end
            if ((state == ADDR || state == DATA) && s_hs) begin
                if (state == ADDR) begin
                    addr_q <= {addr_q[AXIL_ADDR_WIDTH-9:0], s_byte};
                end else if (cnt_q < NB_CNT) begin
                    data_q <= {data_q[AXIL_DATA_WIDTH-9:0], s_byte};
                end
                cnt_q <= field_end ? 8'd0 : cnt_q + 8'd1;
            end
            if (state != AXI_W && state_nxt == AXI_W) begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
            end else begin
                if (m_axil_awready) begin
                    awvalid_q <= 1'b0;
                end
                if (m_axil_wready) begin
                    wvalid_q <= 1'b0;
                end
            end
        end
    end

`ifdef AXIL_MASTER_WSTRB_EN
    logic [NB-1:0] wstrb_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wstrb_q <= '1;
        end else if (state == IDLE && s_hs) begin
            wstrb_q <= '1;
        end else if (state == DATA && s_hs && cnt_q == NB_CNT) begin
            wstrb_q <= s_byte[NB-1:0];
        end
    end

    assign m_axil_wstrb = wstrb_q;
`else
    assign m_axil_wstrb = '1;
`endif

    assign m_axil_awaddr  = addr_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_wdata   = data_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wvalid  = wvalid_q;

    axis_resp_serializer #(
        .NB (NB)
    ) u_resp (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load        (ser_load),
        .load_status (ser_status),
        .load_data   (ser_data),
        .load_count  (ser_count),
        .tdata       (m_axis_tdata),
        .tvalid      (m_axis_tvalid),
        .tready      (m_axis_tready),
        .tlast       (m_axis_tlast)
    );

endmodule

// File: tb/tb_axis_axil_master.sv
// tb/tb_axis_axil_master.sv - scoreboard bench for axis_axil_master with an AXI-Lite slave model
module tb_axis_axil_master;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [31:0] m_axil_awaddr;
    logic [2:0]  m_axil_awprot;
    logic        m_axil_awvalid;
    logic        m_axil_awready = 1'b0;
    logic [31:0] m_axil_wdata;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_wvalid;
    logic        m_axil_wready = 1'b0;
    logic [1:0]  m_axil_bresp = '0;
    logic        m_axil_bvalid = 1'b0;
    logic        m_axil_bready;
    logic [31:0] m_axil_araddr;
    logic [2:0]  m_axil_arprot;
    logic        m_axil_arvalid;
    logic        m_axil_arready = 1'b0;
    logic [31:0] m_axil_rdata = '0;
    logic [1:0]  m_axil_rresp = '0;
    logic        m_axil_rvalid = 1'b0;
    logic        m_axil_rready;

    int vectors = 0;
    int miscompares = 0;

    wr_t        exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [8:0] exp_resp[$];

    int          aw_delay = 0;
    int          w_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    bit          r_hang = 1'b0;
    int          m_stall = 0;
    int          aw_count = 0;
    int          ar_count = 0;

    always #5 clk = ~clk;

    axis_axil_master dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_awprot  (m_axil_awprot),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_bresp   (m_axil_bresp),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arprot  (m_axil_arprot),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready)
    );

    // AXI-Lite slave: readies and responses are driven on the falling edge, so a
    // ready driven here while the DUT valid is high is a handshake at the next rising edge.
    initial begin : slave
        bit aw_got, w_got, b_hs, ar_got, r_hs;
        int aw_wait, w_wait;
        aw_got = 0; w_got = 0; b_hs = 0; ar_got = 0; r_hs = 0; aw_wait = 0; w_wait = 0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                aw_got = 0; w_got = 0; b_hs = 0; ar_got = 0; r_hs = 0; aw_wait = 0; w_wait = 0;
                m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0;
                m_axil_arready = 0; m_axil_rvalid = 0;
            end else begin
                if (b_hs) begin
                    m_axil_bvalid = 0; b_hs = 0; aw_got = 0; w_got = 0;
                end else if (aw_got && w_got) begin
                    m_axil_bvalid = 1; m_axil_bresp = bresp_cfg;
                    if (m_axil_bready) begin
                        b_hs = 1;
                        if (exp_wr.size() > 0) void'(exp_wr.pop_front());
                    end
                end
                if (m_axil_awready) begin
                    m_axil_awready = 0;
                    if (m_axil_awvalid) begin
                        vectors++; miscompares++;
                        $display("FAIL aw_dup: awvalid=%b after handshake, want 0", m_axil_awvalid);
                    end
                end else if (m_axil_awvalid && !aw_got) begin
                    vectors++;
                    if (exp_wr.size() == 0) begin
                        miscompares++;
                        $display("FAIL aw_unexpected: awaddr=%h with no write expected", m_axil_awaddr);
                    end else if (m_axil_awaddr !== exp_wr[0].addr || m_axil_awprot !== 3'b000) begin
                        miscompares++;
                        $display("FAIL aw_addr: got %h/%b want %h/000", m_axil_awaddr, m_axil_awprot, exp_wr[0].addr);
                    end
                    if (aw_wait < aw_delay) begin
                        aw_wait++;
                    end else begin
                        m_axil_awready = 1; aw_got = 1; aw_wait = 0; aw_count++;
                    end
                end
                if (m_axil_wready) begin
                    m_axil_wready = 0;
                    if (m_axil_wvalid) begin
                        vectors++; miscompares++;
                        $display("FAIL w_dup: wvalid=%b after handshake, want 0", m_axil_wvalid);
                    end
                end else if (m_axil_wvalid && !w_got) begin
                    vectors++;
                    if (exp_wr.size() == 0) begin
                        miscompares++;
                        $display("FAIL w_unexpected: wdata=%h with no write expected", m_axil_wdata);
                    end else if (m_axil_wdata !== exp_wr[0].data || m_axil_wstrb !== exp_wr[0].strb) begin
                        miscompares++;
                        $display("FAIL w_data: got %h/%b want %h/%b", m_axil_wdata, m_axil_wstrb, exp_wr[0].data, exp_wr[0].strb);
                    end
                    if (w_wait < w_delay) begin
                        w_wait++;
                    end else begin
                        m_axil_wready = 1; w_got = 1; w_wait = 0;
                    end
                end
                if (r_hs) begin
                    m_axil_rvalid = 0; r_hs = 0; ar_got = 0;
                end else if (ar_got && !r_hang) begin
                    m_axil_rvalid = 1; m_axil_rdata = rdata_cfg; m_axil_rresp = rresp_cfg;
                    if (m_axil_rready) r_hs = 1;
                end
                if (m_axil_arready) begin
                    m_axil_arready = 0;
                    if (m_axil_arvalid) begin
                        vectors++; miscompares++;
                        $display("FAIL ar_dup: arvalid=%b after handshake, want 0", m_axil_arvalid);
                    end
                end else if (m_axil_arvalid && !ar_got) begin
                    vectors++;
                    m_axil_arready = 1; ar_got = 1; ar_count++;
                    if (exp_rd.size() == 0) begin
                        miscompares++;
                        $display("FAIL ar_unexpected: araddr=%h with no read expected", m_axil_araddr);
                    end else begin
                        if (m_axil_araddr !== exp_rd[0] || m_axil_arprot !== 3'b000) begin
                            miscompares++;
                            $display("FAIL ar_addr: got %h/%b want %h/000", m_axil_araddr, m_axil_arprot, exp_rd[0]);
                        end
                        void'(exp_rd.pop_front());
                    end
                end
            end
        end
    end

    // Response scoreboard: every byte offered is compared with the queue head; it is
    // popped only when tready is driven high, so stalled bytes are rechecked each cycle.
    initial begin : resp_mon
        forever begin
            @(negedge clk);
            if (rst_i) begin
                m_axis_tready = 1;
            end else if (m_axis_tvalid) begin
                if (m_stall > 0) begin
                    m_axis_tready = 0; m_stall--;
                end else begin
                    m_axis_tready = 1;
                end
                vectors++;
                if (exp_resp.size() == 0) begin
                    miscompares++;
                    $display("FAIL resp_unexpected: byte %h last %b with none expected", m_axis_tdata, m_axis_tlast);
                end else begin
                    if ({m_axis_tlast, m_axis_tdata} !== exp_resp[0]) begin
                        miscompares++;
                        $display("FAIL resp_byte: got last=%b data=%h want last=%b data=%h",
                                 m_axis_tlast, m_axis_tdata, exp_resp[0][8], exp_resp[0][7:0]);
                    end
                    if (m_axis_tready) void'(exp_resp.pop_front());
                end
            end else begin
                m_axis_tready = 1;
            end
        end
    end

    task automatic send_frame(input byte_q_t bytes);
        int n;
        for (int i = 0; i < bytes.size(); i++) begin
            s_axis_tdata = bytes[i];
            s_axis_tlast = (i == bytes.size() - 1);
            s_axis_tvalid = 1;
            n = 0;
            while (!s_axis_tready && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (n >= 300) begin
                vectors++; miscompares++;
                $display("FAIL send_timeout: tready=%b at byte %0d, want 1", s_axis_tready, i);
                break;
            end
            @(negedge clk);
        end
        s_axis_tvalid = 0;
        s_axis_tlast = 0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_resp.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 500) begin
            miscompares++;
            $display("FAIL %s_timeout: pending resp=%0d wr=%0d rd=%0d, want 0", name, exp_resp.size(), exp_wr.size(), exp_rd.size());
            exp_resp.delete(); exp_wr.delete(); exp_rd.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic push_read_resp(input logic [1:0] rresp, input logic [31:0] rdata);
        exp_resp.push_back({1'b0, 6'b0, rresp});
        exp_resp.push_back({1'b0, rdata[31:24]});
        exp_resp.push_back({1'b0, rdata[23:16]});
        exp_resp.push_back({1'b0, rdata[15:8]});
        exp_resp.push_back({1'b1, rdata[7:0]});
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if (s_axis_tready !== 0 || m_axis_tvalid !== 0 || m_axil_awvalid !== 0 || m_axil_wvalid !== 0 ||
            m_axil_arvalid !== 0 || m_axil_bready !== 0 || m_axil_rready !== 0) begin
            miscompares++;
            $display("FAIL %s_ctrl: tready=%b tvalid=%b aw=%b w=%b ar=%b b=%b r=%b want all 0", name, s_axis_tready,
                     m_axis_tvalid, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready);
        end
        vectors++;
        if (m_axil_wstrb !== 4'hF || m_axis_tdata !== 8'h00 || m_axil_awaddr !== 0 || m_axil_araddr !== 0 || m_axil_wdata !== 0) begin
            miscompares++;
            $display("FAIL %s_data: wstrb=%h tdata=%h awaddr=%h araddr=%h wdata=%h want f/0/0/0/0", name, m_axil_wstrb,
                     m_axis_tdata, m_axil_awaddr, m_axil_araddr, m_axil_wdata);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_i = 0;
        #1;
        vectors++;
        if (s_axis_tready !== 0) begin
            miscompares++;
            $display("FAIL reset_tready_early: got %b want 0", s_axis_tready);
        end
        @(negedge clk);
        vectors++;
        if (s_axis_tready !== 1) begin
            miscompares++;
            $display("FAIL reset_tready_release: got %b want 1", s_axis_tready);
        end
    endtask

    task automatic test_write();
        exp_wr.push_back('{addr: 32'h43C00004, data: 32'hDEADBEEF, strb: 4'hF});
        exp_resp.push_back({1'b1, 8'h00});
        send_frame('{8'h01, 8'h43, 8'hC0, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
        wait_done("write");
    endtask

    task automatic test_read();
        rdata_cfg = 32'h12345678;
        rresp_cfg = 2'b00;
        exp_rd.push_back(32'h43C10000);
        push_read_resp(2'b00, 32'h12345678);
        send_frame('{8'h02, 8'h43, 8'hC1, 8'h00, 8'h00});
        wait_done("read_okay");
        rresp_cfg = 2'b10;
        exp_rd.push_back(32'h43C10000);
        push_read_resp(2'b10, 32'h12345678);
        send_frame('{8'h02, 8'h43, 8'hC1, 8'h00, 8'h00});
        wait_done("read_slverr");
        rresp_cfg = 2'b00;
    endtask

    task automatic test_frame_errors();
        int aw0, ar0;
        aw0 = aw_count;
        ar0 = ar_count;
        exp_resp.push_back({1'b1, 8'h80});
        send_frame('{8'h7F, 8'h11, 8'h22, 8'h33});
        wait_done("illegal_op");
        exp_resp.push_back({1'b1, 8'h80});
        send_frame('{8'h01, 8'h43, 8'hC0});
        wait_done("short_frame");
        exp_resp.push_back({1'b1, 8'h80});
        send_frame('{8'h01, 8'h43, 8'hC0, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        wait_done("long_frame");
        exp_resp.push_back({1'b1, 8'h80});
        send_frame('{8'h02});
        wait_done("opcode_tlast");
        vectors++;
        if (aw_count !== aw0 || ar_count !== ar0) begin
            miscompares++;
            $display("FAIL frame_err_axi: aw=%0d ar=%0d transactions, want 0", aw_count - aw0, ar_count - ar0);
        end
    endtask

    task automatic test_backpressure();
        int n;
        aw_delay = 5;
        w_delay = 1;
        m_stall = 4;
        bresp_cfg = 2'b01;
        exp_wr.push_back('{addr: 32'h43C00010, data: 32'hA5A55A5A, strb: 4'hF});
        exp_resp.push_back({1'b1, 8'h01});
        send_frame('{8'h01, 8'h43, 8'hC0, 8'h00, 8'h10, 8'hA5, 8'hA5, 8'h5A, 8'h5A});
        n = 0;
        while (exp_resp.size() != 0 && n < 500) begin
            vectors++;
            if (s_axis_tready !== 0) begin
                miscompares++;
                $display("FAIL bp_tready: got %b during transaction, want 0", s_axis_tready);
            end
            @(negedge clk);
            n++;
        end
        wait_done("backpressure");
        aw_delay = 0;
        w_delay = 0;
        bresp_cfg = 2'b00;
    endtask

    task automatic test_back_to_back();
        exp_wr.push_back('{addr: 32'h43C00020, data: 32'h01020304, strb: 4'hF});
        exp_resp.push_back({1'b1, 8'h00});
        rdata_cfg = 32'h89ABCDEF;
        exp_rd.push_back(32'h43C00024);
        push_read_resp(2'b00, 32'h89ABCDEF);
        send_frame('{8'h01, 8'h43, 8'hC0, 8'h00, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04});
        send_frame('{8'h02, 8'h43, 8'hC0, 8'h00, 8'h24});
        wait_done("back_to_back");
    endtask

    task automatic test_reset_mid();
        int n;
        r_hang = 1;
        exp_rd.push_back(32'h43C10008);
        send_frame('{8'h02, 8'h43, 8'hC1, 8'h00, 8'h08});
        n = 0;
        while (!m_axil_rready && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 100) begin
            miscompares++;
            $display("FAIL mid_rready_timeout: rready=%b want 1", m_axil_rready);
        end
        rst_i = 1;
        #1;
        check_reset_outputs("mid_reset");
        repeat (3) @(negedge clk);
        r_hang = 0;
        rst_i = 0;
        @(negedge clk);
        rdata_cfg = 32'hCAFEF00D;
        exp_rd.push_back(32'h43C1000C);
        push_read_resp(2'b00, 32'hCAFEF00D);
        send_frame('{8'h02, 8'h43, 8'hC1, 8'h00, 8'h0C});
        wait_done("after_reset");
    endtask

    task automatic test_wstrb();
        int aw0;
        aw0 = aw_count;
`ifdef AXIL_MASTER_WSTRB_EN
        exp_wr.push_back('{addr: 32'h43C00000, data: 32'hAABBCCDD, strb: 4'b0101});
        exp_resp.push_back({1'b1, 8'h00});
`else
        exp_resp.push_back({1'b1, 8'h80});
`endif
        send_frame('{8'h03, 8'h43, 8'hC0, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h05});
        wait_done("wstrb");
        vectors++;
`ifdef AXIL_MASTER_WSTRB_EN
        if (aw_count - aw0 !== 1) begin
`else
        if (aw_count - aw0 !== 0) begin
`endif
            miscompares++;
            $display("FAIL wstrb_axi_count: got %0d write transactions", aw_count - aw0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_frame_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wstrb();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_axil_master.md
Name: axis_axil_master

Overview:
AXI-Lite initiator driven by a byte-wide AXI-Stream command channel. It returns status and read data on a byte-wide AXI-Stream response channel. It lets the PS DMA MM2S/S2MM path (or a UART byte bridge) issue register reads and writes into the PL AXI-Lite slave fabric, acting as the master end of the same bus the PS drives.

Parameters:
AXIL_ADDR_WIDTH, 32, AXI-Lite address width; a multiple of 8.
AXIL_DATA_WIDTH, 32, AXI-Lite data width; a multiple of 8. NB = AXIL_DATA_WIDTH/8 and NA = AXIL_ADDR_WIDTH/8.
AXIS_DATA_WIDTH, 8, stream width; only 8 is supported, with an elaboration-time assertion.

Ports:
clk_i  input  1  single clock for all logic
rst_i  input  1  asynchronous, active-high reset
s_axis  axis_if.slave  tdata 8 / tvalid / tready / tlast  command bytes in
m_axis  axis_if.master  tdata 8 / tvalid / tready / tlast  response bytes out
m_axil  axil_if.master  AXIL_ADDR_WIDTH / AXIL_DATA_WIDTH  AW/W/B/AR/R channels, awprot = arprot = 3'b000

Behaviour:
- Reset is asynchronous and active-high on rst_i, clocked by clk_i. The following apply while rst_i is high:
  - all valids are 0: awvalid, wvalid, arvalid, m_axis.tvalid;
  - bready, rready and s_axis.tready are 0;
  - the FSM is in IDLE;
  - wstrb is all ones, and tdata/addr/data registers are 0.
  - s_axis.tready goes to 1 on the first clk_i edge after rst_i falls.
- Command frame: every multi-byte field is sent MSB byte first.
  - Byte 0 is the opcode: 0x01 = WRITE, 0x02 = READ.
  - Then NA address bytes.
  - WRITE then carries NB data bytes.
  - tlast is required on the final byte.
- FSM states: IDLE, ADDR, DATA, AXI_W, AXI_B, AXI_AR, AXI_R, RESP, DRAIN, ERR.
  - s_axis.tready = 1 only in IDLE, ADDR, DATA and DRAIN.
- IDLE: on an accepted byte, a legal opcode goes to ADDR.
  - An illegal opcode goes to DRAIN, or straight to ERR if that byte carries tlast.
  - tlast on the opcode byte of a legal opcode also goes to ERR (short frame).
- ADDR / DATA: each accepted byte shifts into its register.
  - tlast before the expected last byte → ERR (short frame).
  - The expected last byte without tlast → DRAIN (long frame).
  - The expected last byte with tlast → AXI_W (WRITE) or AXI_AR (READ).
- DRAIN: discards bytes until a byte with tlast is accepted, then goes to ERR. No AXI transaction is issued.
- AXI_W: awvalid and wvalid assert in the cycle after the last command byte is accepted.
  - Each valid drops independently on its own handshake; either order and simultaneous handshakes are legal.
  - When both are done → AXI_B with bready = 1.
  - On bvalid → RESP, with status = {6'b0, bresp}.
- AXI_AR: arvalid is held until arready. Then AXI_R with rready = 1.
  - On rvalid: capture rdata and go to RESP, with status = {6'b0, rresp}.
- Valids and payloads stay stable until handshake. No timeout exists, so a hung slave stalls the block until reset.
- RESP: m_axis.tvalid asserts in the cycle after the B or R handshake.
  - WRITE emits 1 byte: status, with tlast.
  - READ emits 1+NB bytes: status, then rdata MSB first, with tlast on the last byte. Data is sent even when rresp is nonzero.
  - Each byte holds until tready. Return to IDLE in the cycle after the last byte's handshake.
- ERR: emits one byte 0x80 with tlast, then returns to IDLE.
- Status byte layout: bit7 = frame error, bits[1:0] = AXI resp.
- Only one transaction is outstanding at a time. A new command is not accepted until the response completes.
- Reset asserted mid-transaction aborts immediately with all outputs at their reset values. A partial frame is lost and no response is sent.

Optional Feature:
Macro AXIL_MASTER_WSTRB_EN.
- Defined: opcode 0x03 = WRITE_STRB. Frame is opcode, NA address bytes, NB data bytes, then one strobe byte. The low NB bits of the strobe byte drive wstrb for that write; plain WRITE still uses all ones.
- Not defined: 0x03 is an illegal opcode (DRAIN/ERR, response 0x80) and wstrb is constant all ones.

Decomposition:
- Package axis_axil_master_pkg holds:
  - the opcode constants: OP_WRITE, OP_READ, OP_WRITE_STRB;
  - the status bit positions: ST_FRAME_ERR = 7, ST_RESP_LSB = 0;
  - the ERR_STATUS constant 0x80;
  - the state_t enum.
- One sub-module is natural: axis_resp_serializer. It loads {status, data} with a byte count and shifts bytes out with valid/ready and tlast on the final byte.

Test Plan:
- WRITE 01 43C00004 DEADBEEF with tlast on the last byte, slave bresp=00 → one AW/W beat with awaddr 0x43C00004 and wdata 0xDEADBEEF; response 0x00 with tlast.
- READ 02 43C10000, slave returns 0x12345678 with rresp=00 → response 00 12 34 56 78, tlast on 0x78. Repeat with rresp=10 → first byte 0x02, data still sent.
- Illegal opcode 0x7F followed by 3 bytes with tlast → no AXI activity; response 0x80. Short frame 01 43 C0 with tlast → 0x80. A 10-byte WRITE frame → drained, 0x80.
- Backpressure: delay awready 5 cycles and wready 1 cycle, hold m_axis.tready low 4 cycles → valids and payloads stable, no duplicate handshake, s_axis.tready = 0 throughout.
- Assert rst_i while waiting for rvalid → outputs at reset values immediately. A following READ completes normally with no stale response.
- With AXIL_MASTER_WSTRB_EN defined, 03 43C00000 AABBCCDD 05 → wstrb = 4'b0101. Without the macro, the same frame → 0x80 and no AXI activity.
